// File: rtl/wash_program_scheduler_pkg.sv
// Shared codes and timing constants for the wash program scheduler.
// FILL_WATCHDOG_EN (optional) enables the add_water fill watchdog.
package wash_program_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAITGO = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } sched_state_t;

    localparam logic [2:0] PH_CHECK_DOOR    = 3'd0;
    localparam logic [2:0] PH_ADD_WATER     = 3'd1;
    localparam logic [2:0] PH_ADD_DETERGENT = 3'd2;
    localparam logic [2:0] PH_WASH          = 3'd3;
    localparam logic [2:0] PH_RINSE         = 3'd4;
    localparam logic [2:0] PH_SPIN          = 3'd5;

    localparam logic [1:0] PROG_QUICK    = 2'd0;
    localparam logic [1:0] PROG_NORMAL   = 2'd1;
    localparam logic [1:0] PROG_HEAVY    = 2'd2;
    localparam logic [1:0] PROG_RESERVED = 2'd3;

    localparam logic [2:0] WAITGO_CYCLES = 3'd4;
    localparam logic [7:0] FILL_LIMIT    = 8'd64;

    typedef struct packed {
        logic [7:0] wash;
        logic [7:0] rinse;
        logic [7:0] spin;
    } limits_t;

    function automatic limits_t prog_limits(input logic [1:0] prog);
        limits_t lim;
        case (prog)
            PROG_NORMAL: lim = '{wash: 8'd16, rinse: 8'd8,  spin: 8'd8};
            PROG_HEAVY:  lim = '{wash: 8'd32, rinse: 8'd16, spin: 8'd12};
            default:     lim = '{wash: 8'd8,  rinse: 8'd4,  spin: 8'd4};
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/wash_program_scheduler_phase_timer.sv
// Per-phase cycle counter and timeout compare for the RUN state.
// FILL_WATCHDOG_EN (optional) adds the add_water expiry flag.
module phase_timer
    import wash_program_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] prog,
    input  logic [2:0] phase,
    output logic       wash_timeout,
    output logic       rinse_timeout,
    output logic       spin_timeout,
    output logic       fill_expired
);

    logic [7:0] cnt_q;
    logic [7:0] count;
    logic [2:0] phase_q;
    logic       tracking_q;
    limits_t    lim;

    // The count reads 0 in the very first cycle a new phase code is seen.
    assign count = (tracking_q && (phase == phase_q)) ? cnt_q : 8'd0;
    assign lim   = prog_limits(prog);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 8'd0;
            phase_q    <= PH_CHECK_DOOR;
            tracking_q <= 1'b0;
        end else if (!run) begin
            cnt_q      <= 8'd0;
            phase_q    <= PH_CHECK_DOOR;
            tracking_q <= 1'b0;
        end else begin
            cnt_q      <= (count == 8'hFF) ? count : count + 8'd1;
            phase_q    <= phase;
            tracking_q <= 1'b1;
        end
    end

    assign wash_timeout  = run && (phase == PH_WASH)  && (count >= lim.wash  - 8'd1);
    assign rinse_timeout = run && (phase == PH_RINSE) && (count >= lim.rinse - 8'd1);
    assign spin_timeout  = run && (phase == PH_SPIN)  && (count >= lim.spin  - 8'd1);

`ifdef FILL_WATCHDOG_EN
    assign fill_expired = run && (phase == PH_ADD_WATER) && (count == FILL_LIMIT - 8'd1);
`else
    assign fill_expired = 1'b0;
`endif

endmodule

// File: rtl/wash_program_scheduler.sv
// Wash program scheduler: starts the washer, times its phases, reports status.
// FILL_WATCHDOG_EN (optional) makes a stalled add_water phase latch a fault.
module wash_program_scheduler
    import wash_program_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_valid,
    input  logic [1:0] prog_sel,
    input  logic       fault_clr,
    input  logic [2:0] wsh_state,
    input  logic       wsh_done,
    output logic       wsh_start,
    output logic       wash_timeout,
    output logic       rinse_timeout,
    output logic       spin_timeout,
    output logic       busy,
    output logic       cycle_done,
    output logic       start_rej,
    output logic       fault
);

    sched_state_t state_q, state_d;
    logic [1:0]   prog_q, prog_d;
    logic [2:0]   wait_q, wait_d;
    logic         rej_d, done_d;
    logic         run;
    logic         fill_expired;

    assign run = (state_q == S_RUN);

    phase_timer u_phase_timer (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .prog          (prog_q),
        .phase         (wsh_state),
        .wash_timeout  (wash_timeout),
        .rinse_timeout (rinse_timeout),
        .spin_timeout  (spin_timeout),
        .fill_expired  (fill_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prog_q     <= PROG_QUICK;
            wait_q     <= 3'd0;
            start_rej  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            wait_q     <= wait_d;
            start_rej  <= rej_d;
            cycle_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        wait_d  = wait_q;
        rej_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prog_valid) begin
                    if (prog_sel == PROG_RESERVED) begin
                        rej_d = 1'b1;
                    end else begin
                        prog_d  = prog_sel;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                wait_d  = 3'd0;
                state_d = S_WAITGO;
            end
            // A washer still reporting check_door after the grace window has its lid open.
            S_WAITGO: begin
                if (wsh_state != PH_CHECK_DOOR) begin
                    state_d = S_RUN;
                end else if (wait_q == WAITGO_CYCLES - 3'd1) begin
                    state_d = S_IDLE;
                    rej_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_RUN: begin
                if (wsh_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (fill_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wsh_start = (state_q == S_START);
    assign busy      = (state_q == S_START) || (state_q == S_WAITGO) || (state_q == S_RUN);

`ifdef FILL_WATCHDOG_EN
    assign fault = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_wash_program_scheduler.sv
// Self-checking bench for wash_program_scheduler against a cycle-level reference model.
// Build with FILL_WATCHDOG_EN defined to exercise the fill watchdog.
module tb_wash_program_scheduler;

    logic       clk;
    logic       reset;
    logic       prog_valid;
    logic [1:0] prog_sel;
    logic       fault_clr;
    logic [2:0] wsh_state;
    logic       wsh_done;
    logic       wsh_start;
    logic       wash_timeout;
    logic       rinse_timeout;
    logic       spin_timeout;
    logic       busy;
    logic       cycle_done;
    logic       start_rej;
    logic       fault;

    wash_program_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .prog_valid    (prog_valid),
        .prog_sel      (prog_sel),
        .fault_clr     (fault_clr),
        .wsh_state     (wsh_state),
        .wsh_done      (wsh_done),
        .wsh_start     (wsh_start),
        .wash_timeout  (wash_timeout),
        .rinse_timeout (rinse_timeout),
        .spin_timeout  (spin_timeout),
        .busy          (busy),
        .cycle_done    (cycle_done),
        .start_rej     (start_rej),
        .fault         (fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "time limit");
    end

`ifdef FILL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_START  = 1;
    localparam int M_WAITGO = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    int lim_wash[3]  = '{8, 16, 32};
    int lim_rinse[3] = '{4, 8, 16};
    int lim_spin[3]  = '{4, 8, 12};

    // reference model state
    int m_mode;
    int m_prog;
    int m_waitgo_cycles;
    int m_run_len;
    int m_prev_ws;
    bit m_prev_run;
    bit m_rej;
    bit m_done;

    bit e_wash, e_rinse, e_spin;
    logic o_wash, o_rinse, o_spin;

    int n_tests;
    int n_fail;
    int done_seen;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t observed=%0b expected=%0b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s at %0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    function automatic bit exp_to(input int p);
        return (p == 3) ? e_wash : (p == 4) ? e_rinse : e_spin;
    endfunction

    function automatic bit obs_to(input int p);
        return (p == 3) ? (o_wash === 1'b1) : (p == 4) ? (o_rinse === 1'b1) : (o_spin === 1'b1);
    endfunction

    function automatic bit rnd_pv(input bit inject);
        return inject && ($urandom_range(0, 3) == 0);
    endfunction

    function automatic logic [1:0] rnd_sel();
        return 2'($urandom_range(0, 3));
    endfunction

    // driver: one clock cycle -- drive, check against model, advance model at the edge
    task automatic cycle(input bit pv, input logic [1:0] sel, input bit fc,
                         input logic [2:0] ws, input bit wd, input bit rst);
        int  run_len_now;
        int  nxt_mode;
        bit  nrej, ndone;
        prog_valid = pv;
        prog_sel   = sel;
        fault_clr  = fc;
        wsh_state  = ws;
        wsh_done   = wd;
        reset      = rst;
        #1;
        // cycles spent so far (inclusive) in the current washer phase while running
        if (m_mode == M_RUN)
            run_len_now = (m_prev_run && (int'(ws) == m_prev_ws)) ? m_run_len + 1 : 1;
        else
            run_len_now = 0;
        e_wash  = (m_mode == M_RUN) && (ws == 3'd3) && (run_len_now >= lim_wash[m_prog]);
        e_rinse = (m_mode == M_RUN) && (ws == 3'd4) && (run_len_now >= lim_rinse[m_prog]);
        e_spin  = (m_mode == M_RUN) && (ws == 3'd5) && (run_len_now >= lim_spin[m_prog]);
        o_wash  = wash_timeout;
        o_rinse = rinse_timeout;
        o_spin  = spin_timeout;
        chk("wsh_start", wsh_start, m_mode == M_START);
        chk("busy", busy, (m_mode == M_START) || (m_mode == M_WAITGO) || (m_mode == M_RUN));
        chk("fault", fault, m_mode == M_FAULT);
        chk("start_rej", start_rej, m_rej);
        chk("cycle_done", cycle_done, m_done);
        chk("wash_timeout", wash_timeout, e_wash);
        chk("rinse_timeout", rinse_timeout, e_rinse);
        chk("spin_timeout", spin_timeout, e_spin);
        if (cycle_done === 1'b1) done_seen++;
        @(posedge clk);
        if (rst) begin
            m_mode     = M_IDLE;
            m_prog     = 0;
            m_rej      = 1'b0;
            m_done     = 1'b0;
            m_prev_run = 1'b0;
            m_run_len  = 0;
        end else begin
            nrej     = 1'b0;
            ndone    = 1'b0;
            nxt_mode = m_mode;
            case (m_mode)
                M_IDLE: if (pv) begin
                    if (sel == 2'd3) nrej = 1'b1;
                    else begin
                        m_prog   = int'(sel);
                        nxt_mode = M_START;
                    end
                end
                M_START: begin
                    nxt_mode        = M_WAITGO;
                    m_waitgo_cycles = 0;
                end
                M_WAITGO: begin
                    m_waitgo_cycles++;
                    if (ws != 3'd0) nxt_mode = M_RUN;
                    else if (m_waitgo_cycles == 4) begin
                        nxt_mode = M_IDLE;
                        nrej     = 1'b1;
                    end
                end
                M_RUN: begin
                    if (wd) begin
                        nxt_mode = M_IDLE;
                        ndone    = 1'b1;
                    end else if (WD_EN && (ws == 3'd1) && (run_len_now == 64)) begin
                        nxt_mode = M_FAULT;
                    end
                end
                M_FAULT: if (fc) nxt_mode = M_IDLE;
                default: nxt_mode = M_IDLE;
            endcase
            m_prev_run = (m_mode == M_RUN);
            m_run_len  = run_len_now;
            m_prev_ws  = int'(ws);
            m_mode     = nxt_mode;
            m_rej      = nrej;
            m_done     = ndone;
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // washer emulator: walks all phases, advancing wash/rinse/spin on the expected timeout
    task automatic run_program(input int prog, input int lid, input int fill, input int det,
                               input bit inject, input int reset_at);
        int n;
        int first;
        int lim;
        int done_before;
        done_before = done_seen;
        cycle(1'b1, 2'(prog), 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < lid; i++) cycle(rnd_pv(inject), rnd_sel(), 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < fill; i++) cycle(rnd_pv(inject), rnd_sel(), 1'b0, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < det; i++) cycle(rnd_pv(inject), rnd_sel(), 1'b0, 3'd2, 1'b0, 1'b0);
        for (int p = 3; p <= 5; p++) begin
            lim   = (p == 3) ? lim_wash[prog] : (p == 4) ? lim_rinse[prog] : lim_spin[prog];
            n     = 0;
            first = 0;
            do begin
                cycle(rnd_pv(inject), rnd_sel(), 1'b0, 3'(p), 1'b0, 1'b0);
                n++;
                if (first == 0 && obs_to(p)) first = n;
                if (p == 3 && n == reset_at) begin
                    cycle(1'b0, 2'd0, 1'b0, 3'(p), 1'b0, 1'b1);
                    return;
                end
            end while (!exp_to(p) && n < 300);
            chk_int($sformatf("phase%0d_length", p), first, lim);
        end
        cycle(rnd_pv(inject), rnd_sel(), 1'b0, 3'd0, 1'b1, 1'b0);
        idle_cycles(2);
        chk_int("cycle_done_pulses", done_seen - done_before, 1);
    endtask

    // watchdog scenario: add_water never completes
    task automatic stuck_fill(input int prog, input bit end_with_reset);
        cycle(1'b1, 2'(prog), 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) cycle(1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0, 3'd1, 1'b0, 1'b0);
        if (end_with_reset) begin
            cycle(1'b1, 2'd0, 1'b1, 3'd1, 1'b0, 1'b1);
        end else begin
            cycle(1'b0, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0);
            cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        end
        idle_cycles(2);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        done_seen  = 0;
        reset      = 1'b1;
        prog_valid = 1'b0;
        prog_sel   = 2'd0;
        fault_clr  = 1'b0;
        wsh_state  = 3'd0;
        wsh_done   = 1'b0;
        m_mode     = M_IDLE;
        m_prog     = 0;
        m_waitgo_cycles = 0;
        m_run_len  = 0;
        m_prev_ws  = 0;
        m_prev_run = 1'b0;
        m_rej      = 1'b0;
        m_done     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        idle_cycles(1);

        // reserved program is rejected
        cycle(1'b1, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0);
        idle_cycles(2);

        // normal program, lid closed
        run_program(1, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 4), 1'b0, 0);

        // lid held open, with a request ignored during WAITGO
        cycle(1'b1, 2'($urandom_range(0, 2)), 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0);
        idle_cycles(6);

        // heavy program reset mid-wash, then a quick program
        run_program(2, 1, 3, 2, 1'b0, $urandom_range(3, 20));
        idle_cycles(1);
        run_program(0, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 4), 1'b0, 0);

        // reset wins over a same-cycle request and fault clear
        cycle(1'b1, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1);
        idle_cycles(2);

        // randomized programs with requests sprinkled during the run
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                cycle(1'b1, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0);
                idle_cycles(1);
            end
            run_program($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 6),
                        $urandom_range(1, 4), 1'b1, 0);
        end

        // stalled fill: fault then clear, then fault then reset
        stuck_fill($urandom_range(0, 2), 1'b0);
        stuck_fill($urandom_range(0, 2), 1'b1);
        run_program(0, 0, 2, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_program_scheduler.md
WASH_PROGRAM_SCHEDULER -- requirements
Module: wash_program_scheduler

Interface
- REQ-001 SHALL provide `clk`, input, 1 bit: single clock, all logic on its rising edge.
- REQ-002 SHALL provide `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-003 SHALL provide `prog_valid`, input, 1 bit: program request strobe.
- REQ-004 SHALL provide `prog_sel`, input, 2 bits: 0 quick, 1 normal, 2 heavy, 3 reserved.
- REQ-005 SHALL provide `fault_clr`, input, 1 bit: clears a latched fault.
- REQ-006 SHALL provide `wsh_state`, input, 3 bits: washer phase code (0 check_door, 1 add_water, 2 add_detergent, 3 wash, 4 rinse, 5 spin).
- REQ-007 SHALL provide `wsh_done`, input, 1 bit: washer cycle-complete indication.
- REQ-008 SHALL provide `wsh_start`, output, 1 bit: start request to the washer.
- REQ-009 SHALL provide `wash_timeout`, `rinse_timeout` and `spin_timeout`, outputs, 1 bit each: phase-end signals to the washer.
- REQ-010 SHALL provide `busy`, output, 1 bit: a program is in progress.
- REQ-011 SHALL provide `cycle_done` and `start_rej`, outputs, 1 bit each: single-cycle status pulses.
- REQ-012 SHALL provide `fault`, output, 1 bit: latched fill-watchdog fault.

Function
- REQ-013 SHALL implement states IDLE, START, WAITGO, RUN and FAULT.
- REQ-014 In IDLE, `prog_valid`=1 with `prog_sel`!=3 SHALL latch the program and go to START; with `prog_sel`=3 it SHALL stay in IDLE and pulse `start_rej` for 1 cycle.
- REQ-015 START SHALL assert `wsh_start` for exactly 1 cycle, then go to WAITGO; `wsh_start` SHALL be 0 in every other state.
- REQ-016 WAITGO SHALL go to RUN when `wsh_state`!=0; if `wsh_state` is still 0 after 4 cycles (lid open), it SHALL return to IDLE and pulse `start_rej`.
- REQ-017 RUN SHALL use an 8-bit phase counter: 0 on entry to each new `wsh_state` value, +1 per cycle, saturating at 255.
- REQ-018 Each timeout SHALL be asserted combinationally while `wsh_state` equals its phase and counter >= limit-1, so each phase lasts exactly `limit` cycles.
- REQ-019 Limits SHALL be wash/rinse/spin = quick 8/4/4, normal 16/8/8, heavy 32/16/12.
- REQ-020 In RUN, `wsh_done`=1 SHALL pulse `cycle_done` for 1 cycle and return to IDLE.
- REQ-021 `busy` SHALL be 1 in START, WAITGO and RUN, and 0 in IDLE and FAULT.
- REQ-022 `prog_valid` outside IDLE SHALL be ignored, with no `start_rej` pulse.
- REQ-023 In FAULT, all timeouts and `wsh_start` SHALL be 0 and `fault`=1; `fault_clr`=1 SHALL return the block to IDLE on the next edge.

Reset
- REQ-024 `reset` SHALL force IDLE, clear the counter and latched program, and set all outputs to 0, including mid-RUN and in FAULT.
- REQ-025 `reset` SHALL take priority over `fault_clr` and `prog_valid` in the same cycle.

Configuration
- REQ-026 With `FILL_WATCHDOG_EN` defined, RUN with `wsh_state`=1 SHALL go to FAULT when the counter reaches 64 (64 cycles in add_water).
- REQ-027 Without `FILL_WATCHDOG_EN`, FAULT SHALL be unreachable, `fault` SHALL be tied 0 and `fault_clr` ignored.

Structure
- REQ-028 A shared package SHALL hold the washer phase codes, program codes, the limit table, the WAITGO timeout (4) and the fill limit (64).
- REQ-029 The phase counter plus timeout compare SHALL be one sub-module, `phase_timer`.

Verification
- REQ-030 Normal program, lid closed, water/detergent ready: `wsh_start` is a 1-cycle pulse; wash lasts 16 cycles, rinse 8, spin 8; `cycle_done` pulses once; `busy` then falls.
- REQ-031 `prog_sel`=3 in IDLE: `start_rej` pulses 1 cycle; `busy` stays 0; `wsh_start` stays 0.
- REQ-032 Lid open (`wsh_state` held at 0): `start_rej` pulses 4 cycles after WAITGO entry; state returns to IDLE.
- REQ-033 With `FILL_WATCHDOG_EN` defined, `wsh_state` held at 1: `fault`=1 at count 64 and timeouts stay 0; `fault_clr` returns the block to IDLE with `fault`=0.
- REQ-034 `reset` pulsed mid-wash in a heavy program: next cycle all outputs are 0 and the state is IDLE; a new quick program then runs with an 8-cycle wash phase.
- REQ-035 `prog_valid` pulsed during RUN: no effect on state, timeouts or `start_rej`.
